muldiv_hilo: RTL

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_iter.sv | 30 +++
 rtl/muldiv_hilo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared funct codes and FSM state encoding for the HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == F_MTHI) || (f == F_MTLO) || (f == F_MULT) ||
           (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared 2*WIDTH accumulator: shift-add multiply step or
// restoring-divide step (acc = {remainder, quotient/dividend} when dividing).
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH:0] sum, trial, diff;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, opnd};
    acc_nxt = acc;
    if (is_div) begin
      // borrow out of the W+1-bit trial subtract means divisor did not fit
      if (diff[WIDTH]) acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_nxt = {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// MIPS HI/LO multiply/divide unit: iterative magnitude datapath plus a sign FIX cycle.
// Define MULDIV_FAST_MULT_EN for single-cycle MULT/MULTU; divide stays iterative.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  state_e                state, state_d;
  logic [CW-1:0]         cnt;
  logic [2*WIDTH-1:0]    acc, acc_nxt, prod_fix;
  logic [WIDTH-1:0]      opnd, a_mag, b_mag, q_fix, r_fix;
  logic                  op_div, neg_q, neg_r;
  logic                  accept, is_signed, is_mul, is_div, a_neg, b_neg, zero_div, last;

  assign busy      = (state != IDLE);
  assign accept    = start && !busy && funct_ok(funct);
  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign a_neg     = is_signed && rs_data[WIDTH-1];
  assign b_neg     = is_signed && rt_data[WIDTH-1];
  assign a_mag     = a_neg ? -rs_data : rs_data;
  assign b_mag     = b_neg ? -rt_data : rt_data;
  assign zero_div  = (rt_data == '0);
  assign last      = (cnt == CW'(WIDTH - 1));

  // Sign restoration; most-negative / -1 lands on most-negative with no extra case.
  assign prod_fix  = neg_q ? -acc : acc;
  assign q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_mag;
  assign fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div  (op_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_MULT_EN
          if (is_div && !zero_div) state_d = DIV;
`else
          if (is_mul)                   state_d = MUL;
          else if (is_div && !zero_div) state_d = DIV;
`endif
        end
      end
      MUL, DIV: if (last) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      op_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (funct)
              F_MTHI: hi <= rs_data;
              F_MTLO: lo <= rs_data;
              F_MULT, F_MULTU: begin
`ifdef MULDIV_FAST_MULT_EN
                {hi, lo} <= (a_neg ^ b_neg) ? -fast_mag : fast_mag;
                done     <= 1'b1;
`else
                acc    <= {{WIDTH{1'b0}}, b_mag};
                opnd   <= a_mag;
                op_div <= 1'b0;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= 1'b0;
                cnt    <= '0;
`endif
              end
              F_DIV, F_DIVU: begin
                if (zero_div) begin
                  hi          <= rs_data;
                  lo          <= '1;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                end else begin
                  acc    <= {{WIDTH{1'b0}}, a_mag};
                  opnd   <= b_mag;
                  op_div <= 1'b1;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  cnt    <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (op_div) begin
            lo <= q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
